// File: rtl/atmega_eep_loader.sv
// ============================================================================
// atmega_eep_loader
// ----------------------------------------------------------------------------
// Bulk-transfer engine placed in front of the EEPROM external load/read port.
// A load copies EEP_SIZE bytes from an upstream byte stream into EEPROM
// addresses 0..EEP_SIZE-1. A dump reads every address in order and presents
// the bytes on a downstream byte stream. The engine owns the EEPROM external
// port for the whole transfer, so eep_en stays high from the first cycle of
// an operation to its last, stall cycles included.
//
// Parameters:
//   EEP_SIZE  - bytes moved per operation (2..65536)
//   AUTO_LOAD - nonzero: a load starts on the first edge after reset is released
//
// Ports:
//   clk, rst              - clock and synchronous active-high reset
//   load_start            - one-cycle pulse, start a load (wins over dump_start)
//   dump_start            - one-cycle pulse, start a dump
//   abort                 - cancel the running operation, no done pulse
//   s_data/s_valid/s_ready - upstream byte stream (load source)
//   m_data/m_valid/m_ready - downstream byte stream (dump sink)
//   eep_addr/eep_wdata    - EEPROM external address and write data
//   eep_wr/eep_rd/eep_en  - EEPROM external write strobe, read enable, port enable
//   eep_rdata             - EEPROM external read data (one-cycle read latency)
//   busy                  - an operation is in progress
//   done                  - one-cycle pulse when an operation completes
//   count                 - bytes completed in the current or last operation
// ============================================================================
module atmega_eep_loader #(
   parameter int EEP_SIZE  = 512,
   parameter int AUTO_LOAD = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load_start,
   input  logic        dump_start,
   input  logic        abort,
   input  logic [7:0]  s_data,
   input  logic        s_valid,
   output logic        s_ready,
   output logic [7:0]  m_data,
   output logic        m_valid,
   input  logic        m_ready,
   output logic [16:0] eep_addr,
   output logic [7:0]  eep_wdata,
   output logic        eep_wr,
   output logic        eep_rd,
   output logic        eep_en,
   input  logic [7:0]  eep_rdata,
   output logic        busy,
   output logic        done,
   output logic [16:0] count
);

   localparam logic [16:0] LAST_COUNT = 17'(EEP_SIZE);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      LOAD_WR,
      RD_ADDR,
      RD_WAIT,
      RD_OUT
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [16:0] count_nxt;
   logic [16:0] count_inc;
   logic        done_nxt;
   logic        latch_byte;
   logic        auto_pend;

   assign count_inc = count + 17'd1;

   // The stream handshake signals are the only outputs decoded straight from
   // the state; everything else on the port comes out of a flop.
   assign s_ready  = (state == LOAD);
   assign m_valid  = (state == RD_OUT);

   // count is already a register and always holds the address of the byte in
   // flight, so the EEPROM address is simply its zero-extended value.
   assign eep_addr = count;

   // Next-state decision. Abort takes priority over any handshake in the same
   // cycle so that a cancelled transfer never consumes or emits one more byte.
   // A write already sitting in LOAD_WR is on the port this very cycle, so it
   // still counts as completed when abort arrives alongside it.
   always_comb begin
      state_nxt  = state;
      count_nxt  = count;
      done_nxt   = 1'b0;
      latch_byte = 1'b0;
      case (state)
         IDLE: begin
            if (load_start || auto_pend) begin
               state_nxt = LOAD;
               count_nxt = '0;
            end else if (dump_start) begin
               state_nxt = RD_ADDR;
               count_nxt = '0;
            end
         end
         LOAD: begin
            if (abort) begin
               state_nxt = IDLE;
            end else if (s_valid) begin
               latch_byte = 1'b1;
               state_nxt  = LOAD_WR;
            end
         end
         LOAD_WR: begin
            count_nxt = count_inc;
            if (abort) begin
               state_nxt = IDLE;
            end else if (count_inc == LAST_COUNT) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end else begin
               state_nxt = LOAD;
            end
         end
         RD_ADDR: begin
            state_nxt = abort ? IDLE : RD_WAIT;
         end
         RD_WAIT: begin
            state_nxt = abort ? IDLE : RD_OUT;
         end
         RD_OUT: begin
            if (abort) begin
               state_nxt = IDLE;
            end else if (m_ready) begin
               count_nxt = count_inc;
               if (count_inc == LAST_COUNT) begin
                  state_nxt = IDLE;
                  done_nxt  = 1'b1;
               end else begin
                  state_nxt = RD_ADDR;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State register plus every registered output. The port strobes are
   // computed from the state being entered, so each strobe lines up exactly
   // with the cycle spent in the state that owns it. auto_pend is armed by
   // reset and consumed on the first free-running edge, which turns the
   // AUTO_LOAD option into a one-shot load request.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         count     <= '0;
         done      <= 1'b0;
         busy      <= 1'b0;
         eep_en    <= 1'b0;
         eep_wr    <= 1'b0;
         eep_rd    <= 1'b0;
         eep_wdata <= '0;
         m_data    <= '0;
         auto_pend <= (AUTO_LOAD != 0);
      end else begin
         state     <= state_nxt;
         count     <= count_nxt;
         done      <= done_nxt;
         busy      <= (state_nxt != IDLE);
         eep_en    <= (state_nxt != IDLE);
         eep_wr    <= (state_nxt == LOAD_WR);
         eep_rd    <= (state_nxt == RD_ADDR) || (state_nxt == RD_WAIT);
         auto_pend <= 1'b0;
         if (latch_byte) begin
            eep_wdata <= s_data;
         end
         if (state == RD_WAIT) begin
            m_data <= eep_rdata;
         end
      end
   end

endmodule

// File: tb/tb_atmega_eep_loader.sv
// ============================================================================
// tb_atmega_eep_loader
// ----------------------------------------------------------------------------
// Self-checking bench for atmega_eep_loader with EEP_SIZE=4 and AUTO_LOAD=1.
// A small EEPROM array model answers the external port with one cycle of read
// latency. A cycle table covers reset, the auto-started load and the start
// and abort corner cases; hand-written sequences cover dump flow control,
// abort mid-dump and reset mid-write; random load/dump operations are checked
// against a transaction-level model of what the array must contain.
// ============================================================================
module tb_atmega_eep_loader;

   localparam int SIZE = 4;

   logic        clk        = 1'b0;
   logic        rst        = 1'b1;
   logic        load_start = 1'b0;
   logic        dump_start = 1'b0;
   logic        abort      = 1'b0;
   logic [7:0]  s_data     = 8'h00;
   logic        s_valid    = 1'b0;
   logic        m_ready    = 1'b0;
   logic        s_ready;
   logic        m_valid;
   logic        eep_wr;
   logic        eep_rd;
   logic        eep_en;
   logic        busy;
   logic        done;
   logic [7:0]  m_data;
   logic [7:0]  eep_wdata;
   logic [7:0]  eep_rdata;
   logic [16:0] eep_addr;
   logic [16:0] count;

   int checks = 0;
   int errors = 0;

   logic [7:0] mem         [0:SIZE-1];
   logic [7:0] preload_val [0:SIZE-1];
   logic       preload_req = 1'b0;
   logic [7:0] ref_mem     [0:SIZE-1];

   typedef struct {
      logic        rst;
      logic        ld;
      logic        dp;
      logic        ab;
      logic        sv;
      logic [7:0]  sd;
      logic [6:0]  flags;
      logic [16:0] cnt;
      logic [16:0] addr;
      logic [7:0]  wdata;
   } vec_t;

   vec_t vecs [0:21];

   atmega_eep_loader #(
      .EEP_SIZE (SIZE),
      .AUTO_LOAD(1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .load_start(load_start),
      .dump_start(dump_start),
      .abort     (abort),
      .s_data    (s_data),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .m_data    (m_data),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .eep_addr  (eep_addr),
      .eep_wdata (eep_wdata),
      .eep_wr    (eep_wr),
      .eep_rd    (eep_rd),
      .eep_en    (eep_en),
      .eep_rdata (eep_rdata),
      .busy      (busy),
      .done      (done),
      .count     (count)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // EEPROM array model: synchronous write, synchronous read with one cycle of
   // latency, plus a bench-side preload path used while the engine is idle.
   always @(posedge clk) begin
      if (preload_req) begin
         for (int i = 0; i < SIZE; i++) mem[i] <= preload_val[i];
      end else if (eep_en && eep_wr && eep_addr < 17'(SIZE)) begin
         mem[eep_addr[1:0]] <= eep_wdata;
      end
      if (eep_en && eep_rd) begin
         eep_rdata <= (eep_addr < 17'(SIZE)) ? mem[eep_addr[1:0]] : 8'hEE;
      end
   end

   // Hard stop in case something wedges outside the bounded loops.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // flags order: {s_ready, m_valid, eep_wr, eep_rd, eep_en, busy, done}
   function automatic vec_t mkRow(input logic r, input logic ld, input logic dp, input logic ab,
                                  input logic sv, input logic [7:0] sd, input logic [6:0] fl,
                                  input logic [16:0] cnt, input logic [16:0] ad, input logic [7:0] wd);
      vec_t v;
      v.rst = r;  v.ld = ld; v.dp = dp; v.ab = ab; v.sv = sv; v.sd = sd;
      v.flags = fl; v.cnt = cnt; v.addr = ad; v.wdata = wd;
      return v;
   endfunction

   task automatic applyStimulus(input vec_t v);
      rst        = v.rst;
      load_start = v.ld;
      dump_start = v.dp;
      abort      = v.ab;
      s_valid    = v.sv;
      s_data     = v.sd;
      m_ready    = 1'b0;
   endtask

   task automatic checkRow(input int idx, input vec_t v);
      checkOutput($sformatf("row%0d_flags", idx),
                  {s_ready, m_valid, eep_wr, eep_rd, eep_en, busy, done}, v.flags);
      checkOutput($sformatf("row%0d_count", idx), count, v.cnt);
      if (v.flags[4]) begin
         checkOutput($sformatf("row%0d_addr", idx), eep_addr, v.addr);
         checkOutput($sformatf("row%0d_wdata", idx), eep_wdata, v.wdata);
      end
   endtask

   task automatic preloadMem(input logic [31:0] word);
      for (int i = 0; i < SIZE; i++) begin
         preload_val[i] = word[8*i +: 8];
         ref_mem[i]     = word[8*i +: 8];
      end
      @(negedge clk);
      preload_req = 1'b1;
      @(negedge clk);
      preload_req = 1'b0;
   endtask

   // One randomized load or dump. The model tracks, at transaction level, the
   // k-th accepted byte going to address k, the k-th emitted byte being array
   // entry k, and completion only when all EEP_SIZE bytes moved without abort.
   task automatic runRandomOp(input bit is_load, input int abort_at);
      logic [7:0] pend_data [$];
      int         pend_addr [$];
      int         accepted = 0;
      int         written  = 0;
      int         streamed = 0;
      int         done_busy = 0;
      int         en_gap = 0;
      bit         finished = 0;
      bit         aborted = 0;
      bit         prev_stall = 0;
      logic [7:0] prev_data = 8'h00;
      @(negedge clk);
      load_start = is_load;
      dump_start = !is_load;
      @(negedge clk);
      load_start = 1'b0;
      dump_start = 1'b0;
      for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
         if (eep_wr) begin
            checkOutput("rnd_wr_pending", 32'(accepted > written), 1);
            if (pend_addr.size() > 0) begin
               checkOutput("rnd_wr_addr", eep_addr, pend_addr.pop_front());
               checkOutput("rnd_wr_data", eep_wdata, pend_data.pop_front());
            end
            written++;
         end
         if (!busy) begin
            finished   = 1;
            abort      = 1'b0;
            s_valid    = 1'b0;
            m_ready    = 1'b0;
            checkOutput("rnd_done", done, !aborted);
            checkOutput("rnd_count", count, is_load ? written : streamed);
            if (is_load) checkOutput("rnd_all_written", written, accepted);
            checkOutput("rnd_done_while_busy", done_busy, 0);
            checkOutput("rnd_en_gap", en_gap, 0);
         end else begin
            if (done) done_busy++;
            if (!eep_en) en_gap++;
            if (cyc == abort_at) begin
               abort   = 1'b1;
               s_valid = 1'b0;
               m_ready = 1'b0;
               aborted = 1;
            end else begin
               abort   = 1'b0;
               s_valid = ($urandom_range(0, 3) != 0);
               s_data  = 8'($urandom);
               m_ready = ($urandom_range(0, 2) != 0);
            end
            if (s_valid && s_ready) begin
               pend_addr.push_back(accepted);
               pend_data.push_back(s_data);
               if (accepted < SIZE) ref_mem[accepted] = s_data;
               accepted++;
            end
            if (m_valid) begin
               if (prev_stall) checkOutput("rnd_mdata_hold", m_data, prev_data);
               if (m_ready) begin
                  if (streamed < SIZE) checkOutput("rnd_mdata", m_data, ref_mem[streamed]);
                  streamed++;
               end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            @(negedge clk);
         end
      end
      checkOutput("rnd_finished", finished, 1);
   endtask

   initial begin
      int         first_valid;
      int         k;
      int         done_cnt;
      int         done_cyc;
      int         last_hs;
      int         hs;
      int         en_gap;
      bit         fin;
      bit         prev_stall;
      logic [7:0] prev_data;

      // ---------------- cycle table ----------------
      vecs[0]  = mkRow(1, 0, 0, 0, 0, 8'h00, 7'b0000000, 0, 0, 8'h00);
      vecs[1]  = mkRow(0, 0, 0, 0, 1, 8'hA5, 7'b0000000, 0, 0, 8'h00);
      vecs[2]  = mkRow(0, 0, 0, 0, 1, 8'hA5, 7'b1000110, 0, 0, 8'h00);
      vecs[3]  = mkRow(0, 0, 0, 0, 1, 8'h5A, 7'b0010110, 0, 0, 8'hA5);
      vecs[4]  = mkRow(0, 0, 0, 0, 1, 8'h5A, 7'b1000110, 1, 0, 8'h00);
      vecs[5]  = mkRow(0, 0, 0, 0, 1, 8'h00, 7'b0010110, 1, 1, 8'h5A);
      vecs[6]  = mkRow(0, 0, 0, 0, 1, 8'h00, 7'b1000110, 2, 0, 8'h00);
      vecs[7]  = mkRow(0, 0, 0, 0, 1, 8'hFF, 7'b0010110, 2, 2, 8'h00);
      vecs[8]  = mkRow(0, 0, 0, 0, 1, 8'hFF, 7'b1000110, 3, 0, 8'h00);
      vecs[9]  = mkRow(0, 0, 0, 0, 0, 8'h00, 7'b0010110, 3, 3, 8'hFF);
      vecs[10] = mkRow(0, 0, 0, 0, 0, 8'h00, 7'b0000001, 4, 0, 8'h00);
      vecs[11] = mkRow(0, 1, 1, 0, 0, 8'h00, 7'b0000000, 4, 0, 8'h00);
      vecs[12] = mkRow(0, 0, 0, 0, 0, 8'h00, 7'b1000110, 0, 0, 8'h00);
      vecs[13] = mkRow(0, 0, 0, 0, 1, 8'h3C, 7'b1000110, 0, 0, 8'h00);
      vecs[14] = mkRow(0, 0, 0, 1, 0, 8'h00, 7'b0010110, 0, 0, 8'h3C);
      vecs[15] = mkRow(0, 0, 0, 0, 0, 8'h00, 7'b0000000, 1, 0, 8'h00);
      vecs[16] = mkRow(0, 0, 0, 1, 0, 8'h00, 7'b0000000, 1, 0, 8'h00);
      vecs[17] = mkRow(0, 1, 0, 0, 0, 8'h00, 7'b0000000, 1, 0, 8'h00);
      vecs[18] = mkRow(0, 0, 0, 0, 0, 8'h00, 7'b1000110, 0, 0, 8'h00);
      vecs[19] = mkRow(0, 0, 0, 0, 0, 8'h00, 7'b1000110, 0, 0, 8'h00);
      vecs[20] = mkRow(0, 0, 0, 1, 0, 8'h00, 7'b1000110, 0, 0, 8'h00);
      vecs[21] = mkRow(0, 0, 0, 0, 0, 8'h00, 7'b0000000, 0, 0, 8'h00);

      repeat (2) @(posedge clk);
      for (int i = 0; i < 22; i++) begin
         @(negedge clk);
         applyStimulus(vecs[i]);
         checkRow(i, vecs[i]);
      end
      @(negedge clk);
      applyStimulus(mkRow(0, 0, 0, 0, 0, 8'h00, 7'b0, 0, 0, 8'h00));

      // ---------------- dump with m_ready toggling ----------------
      preloadMem(32'h44332211);
      first_valid = -1; k = 0; done_cnt = 0; done_cyc = -1; last_hs = -1;
      fin = 0; prev_stall = 0; prev_data = 8'h00; en_gap = 0;
      for (int cyc = 0; cyc < 60 && !fin; cyc++) begin
         @(negedge clk);
         if (cyc > 0 && !busy) fin = 1;
         if (busy && !eep_en) en_gap++;
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (cyc == 1) begin
            checkOutput("dump_rd_phase", {eep_rd, eep_en, busy, m_valid}, 4'b1110);
            checkOutput("dump_first_addr", eep_addr, 0);
         end
         dump_start = (cyc == 0);
         m_ready    = ((cyc % 2) == 1);
         if (m_valid) begin
            if (first_valid < 0) first_valid = cyc;
            if (prev_stall) checkOutput("dump_hold", m_data, prev_data);
            if (m_ready) begin
               if (k < SIZE) checkOutput($sformatf("dump_byte%0d", k), m_data, ref_mem[k]);
               k++;
               last_hs = cyc;
            end
         end
         prev_stall = m_valid && !m_ready;
         prev_data  = m_data;
      end
      m_ready = 1'b0;
      checkOutput("dump_finished", fin, 1);
      checkOutput("dump_first_valid_cycle", first_valid, 3);
      checkOutput("dump_bytes", k, 4);
      checkOutput("dump_done_pulses", done_cnt, 1);
      checkOutput("dump_done_timing", done_cyc, last_hs + 1);
      checkOutput("dump_count", count, 4);
      checkOutput("dump_en_gap", en_gap, 0);

      // ---------------- abort during dump after 2 handshakes ----------------
      @(negedge clk);
      dump_start = 1'b1;
      m_ready    = 1'b1;
      @(negedge clk);
      dump_start = 1'b0;
      hs = 0;
      for (int cyc = 0; cyc < 40 && hs < 2; cyc++) begin
         if (m_valid && m_ready) hs++;
         @(negedge clk);
      end
      checkOutput("abort_dump_hs", hs, 2);
      abort   = 1'b1;
      m_ready = 1'b0;
      @(negedge clk);
      abort = 1'b0;
      checkOutput("abort_dump_idle", {m_valid, eep_en, busy, done}, 4'b0000);
      checkOutput("abort_dump_count", count, 2);
      dump_start = 1'b1;
      @(negedge clk);
      dump_start = 1'b0;
      checkOutput("redump_rd", {eep_rd, eep_en}, 2'b11);
      checkOutput("redump_addr", eep_addr, 0);
      checkOutput("redump_count", count, 0);
      for (int w = 0; w < 10 && !m_valid; w++) @(negedge clk);
      checkOutput("redump_valid", m_valid, 1);
      checkOutput("redump_byte0", m_data, ref_mem[0]);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checkOutput("redump_abort_idle", {busy, done, m_valid}, 3'b000);

      // ---------------- reset during LOAD_WR, auto-load on release ----------------
      @(negedge clk);
      load_start = 1'b1;
      @(negedge clk);
      load_start = 1'b0;
      s_valid    = 1'b1;
      s_data     = 8'h77;
      @(negedge clk);
      s_valid = 1'b0;
      checkOutput("rst_pre_wr", eep_wr, 1);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("rst_flags", {s_ready, m_valid, eep_wr, eep_rd, eep_en, busy, done}, 7'b0000000);
      checkOutput("rst_count", count, 0);
      checkOutput("rst_data", {m_data, eep_wdata}, 16'h0000);
      checkOutput("rst_addr", eep_addr, 0);
      @(negedge clk);
      checkOutput("rst_hold_flags", {s_ready, eep_en, busy}, 3'b000);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("autoload_flags", {s_ready, m_valid, eep_wr, eep_rd, eep_en, busy, done}, 7'b1000110);
      checkOutput("autoload_count", count, 0);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checkOutput("autoload_abort_idle", busy, 0);

      // ---------------- randomized operations ----------------
      preloadMem($urandom);
      for (int n = 0; n < 16; n++) begin
         runRandomOp($urandom_range(0, 1) == 1,
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10)) : -1);
      end
      // A final full dump proves the array holds what the model expects.
      runRandomOp(1'b0, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
